regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3: consecutive ALU losses before ALU is forced to win.
REQ-002 SHALL have port HCLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port HRESET, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports alu_valid (in, 1), alu_ready (out, 1), alu_rd (in, 5) and alu_data (in, 32): the ALU writeback request.
REQ-005 SHALL have ports lsu_valid (in, 1), lsu_ready (out, 1), lsu_rd (in, 5) and lsu_data (in, 32): the load-unit writeback request.
REQ-006 SHALL have ports rsv_valid (in, 1) and rsv_rd (in, 5): reserve a destination register as pending.
REQ-007 SHALL have ports chk_ra (in, 5), chk_rb (in, 5), ra_busy (out, 1) and rb_busy (out, 1): scoreboard lookup.
REQ-008 SHALL have ports WR (out, 1), RW (out, 5) and DW (out, 32): they drive the register-file write port.

Function
REQ-009 SHALL accept at most one writeback per cycle; a handshake is valid and ready both high at a rising edge.
REQ-010 SHALL derive alu_ready and lsu_ready combinationally from the valids and the starvation counter; there is no dependence on the previous cycle's grant.
REQ-011 SHALL grant LSU when only LSU is valid, and ALU when only ALU is valid.
REQ-012 SHALL grant LSU when both are valid and starve_cnt < STARVE_MAX; otherwise it SHALL grant ALU.
REQ-013 SHALL update starve_cnt as follows:
- increment, saturating at STARVE_MAX, on each cycle ALU is valid and not granted;
- clear to 0 on an ALU grant, or on any cycle alu_valid is low.
REQ-014 SHALL register WR, RW and DW on the edge that completes a handshake, with 1-cycle latency.
- WR is high for exactly the following cycle.
- RW and DW hold the granted rd and data.
REQ-015 SHALL set WR low on the cycle after a granted write with rd = 0; the handshake still completes.
REQ-016 SHALL hold RW and DW at their previous values whenever WR is low.
REQ-017 SHALL keep a 32-bit pending bitmap:
- rsv_valid with rsv_rd != 0 sets bit rsv_rd at the edge;
- a cycle with WR high clears bit RW at that edge;
- bit 0 is constant 0.
REQ-018 SHALL let set win over clear when a reservation and a clear hit the same register in the same cycle.
REQ-019 SHALL drive ra_busy = pending[chk_ra] and rb_busy = pending[chk_rb] combinationally, from register state only.
- There is no forwarding.
- Busy drops the cycle after the regfile write edge, when the regfile already holds the new data.
REQ-020 SHALL not check whether the destination of an incoming write is pending; duplicate writes are legal and the last one wins.

Reset
REQ-021 SHALL, while HRESET is high at an edge, clear WR, RW, DW, starve_cnt and all pending bits to 0.
REQ-022 SHALL hold alu_ready and lsu_ready low while HRESET is high.
REQ-023 SHALL let reset mid-operation discard any in-flight registered write: WR is 0 on the cycle after reset.

Structure
REQ-024 SHALL place these in a shared package: REG_ADDR_W = 5, XLEN = 32, NUM_REGS = 32, and the requester-ID encoding (ALU = 0, LSU = 1).
REQ-025 SHALL implement the pending bitmap and busy lookup as one sub-module, regfile_scoreboard.
REQ-026 SHALL keep the arbiter, the starvation counter and the output register in the top module.

Verification
REQ-027 SHALL cover single ALU write:
- stimulus: alu_valid = 1, alu_rd = 5, alu_data = 100;
- required: alu_ready = 1 the same cycle; next cycle WR = 1, RW = 5, DW = 100; the regfile then reads 100 at address 5.
REQ-028 SHALL cover contention:
- stimulus: both valid continuously; LSU rd = 10, data = 200; ALU rd = 20;
- required: LSU granted for 3 cycles, ALU granted on the 4th, then LSU again.
REQ-029 SHALL cover scoreboard:
- stimulus: rsv rd = 20; then chk_ra = 20 until an LSU write to rd 20 with data 0xFFFB6BC2;
- required: ra_busy = 1 from the cycle after reservation through the WR cycle, 0 after; data reads back 0xFFFB6BC2.
REQ-030 SHALL cover the x0 write:
- stimulus: ALU write rd = 0, data = 0x383;
- required: alu_ready = 1, WR stays 0, and pending[0] never sets even with rsv_rd = 0.
REQ-031 SHALL cover set/clear collision:
- stimulus: a write to rd 7 is in its WR cycle while rsv_rd = 7 in the same cycle;
- required: the busy lookup with chk_rb = 7 gives rb_busy = 1 afterwards.
REQ-032 SHALL cover reset mid-operation:
- stimulus: HRESET pulsed on a handshake cycle, with 3 reservations outstanding;
- required: WR = 0 the next cycle, all busy = 0, starve_cnt = 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   REG_ADDR_W : width of a register address (rd / chk fields)
//   XLEN       : width of a writeback data word
//   NUM_REGS   : number of architectural registers tracked by the scoreboard
//   req_id_e   : identity of the writeback requester that won arbitration
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// destination is reserved and cleared when the regfile write for it happens.
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_set_valid, i_set_rd   : reserve register i_set_rd as pending
//   i_clr_valid, i_clr_rd   : the regfile write to i_clr_rd happens this edge
//   i_chk_ra, i_chk_rb      : lookup addresses
//   o_ra_busy, o_rb_busy    : pending state of the looked-up registers
module regfile_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_set_valid,
  input  logic [REG_ADDR_W-1:0] i_set_rd,
  input  logic                  i_clr_valid,
  input  logic [REG_ADDR_W-1:0] i_clr_rd,
  input  logic [REG_ADDR_W-1:0] i_chk_ra,
  input  logic [REG_ADDR_W-1:0] i_chk_rb,
  output logic                  o_ra_busy,
  output logic                  o_rb_busy
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_next;

  // Clear is applied before set so a reservation landing on the same edge as
  // the write that retires the old value keeps the register pending for the
  // new producer. x0 is hardwired, so its bit is forced low after both.
  always_comb begin
    w_pending_next = r_pending;
    if (i_clr_valid) w_pending_next[i_clr_rd] = 1'b0;
    if (i_set_valid) w_pending_next[i_set_rd] = 1'b1;
    w_pending_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_pending <= '0;
    else       r_pending <= w_pending_next;
  end

  // Register state only: no bypass from the write in flight.
  assign o_ra_busy = r_pending[i_chk_ra];
  assign o_rb_busy = r_pending[i_chk_rb];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between the ALU and the load unit for a single regfile
// write port, with a pending-register scoreboard.
// Ports:
//   HCLK, HRESET                          : clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data   : ALU writeback request
//   lsu_valid/lsu_ready/lsu_rd/lsu_data   : load-unit writeback request
//   rsv_valid/rsv_rd                      : reserve a destination as pending
//   chk_ra/chk_rb/ra_busy/rb_busy         : scoreboard lookup
//   WR/RW/DW                              : registered regfile write port
//   dbg_starve_cnt                        : current ALU starvation count
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 3,
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1)
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  rsv_valid,
  input  logic [REG_ADDR_W-1:0] rsv_rd,
  input  logic [REG_ADDR_W-1:0] chk_ra,
  input  logic [REG_ADDR_W-1:0] chk_rb,
  output logic                  ra_busy,
  output logic                  rb_busy,
  output logic                  WR,
  output logic [REG_ADDR_W-1:0] RW,
  output logic [XLEN-1:0]       DW,
  output logic [CNT_W-1:0]      dbg_starve_cnt
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  // Handshake: a request transfers on a rising edge where its valid and
  // ready are both high. Ready is a pure function of the current valids and
  // the starvation count, never of an earlier grant; a requester must hold
  // valid and its payload stable until it sees ready.
  logic                  w_starved;
  logic                  w_grant_alu;
  logic                  w_grant_lsu;
  logic                  w_hs;
  req_id_e               w_grant_id;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [XLEN-1:0]       w_data;

  logic [CNT_W-1:0]      r_starve_cnt;
  logic                  r_wr;
  logic [REG_ADDR_W-1:0] r_rw;
  logic [XLEN-1:0]       r_dw;

  // LSU is preferred under contention until the ALU has lost STARVE_MAX
  // times in a row.
  assign w_starved   = (r_starve_cnt >= STARVE_LIM);
  assign w_grant_alu = ~HRESET & alu_valid & (~lsu_valid | w_starved);
  assign w_grant_lsu = ~HRESET & lsu_valid & (~alu_valid | ~w_starved);
  assign w_hs        = w_grant_alu | w_grant_lsu;
  assign w_grant_id  = w_grant_alu ? REQ_ALU : REQ_LSU;

  assign alu_ready = w_grant_alu;
  assign lsu_ready = w_grant_lsu;

  always_comb begin
    w_rd   = lsu_rd;
    w_data = lsu_data;
    if (w_grant_id == REQ_ALU) begin
      w_rd   = alu_rd;
      w_data = alu_data;
    end
  end

  // Any cycle the ALU is idle or wins resets its loss streak.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_starve_cnt <= '0;
    end else if (!alu_valid || w_grant_alu) begin
      r_starve_cnt <= '0;
    end else if (!w_starved) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  // A granted write to x0 completes its handshake but never reaches the
  // regfile; RW/DW keep their last real write so they only move with WR.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_wr <= 1'b0;
      r_rw <= '0;
      r_dw <= '0;
    end else begin
      r_wr <= 1'b0;
      if (w_hs && (w_rd != '0)) begin
        r_wr <= 1'b1;
        r_rw <= w_rd;
        r_dw <= w_data;
      end
    end
  end

  assign WR             = r_wr;
  assign RW             = r_rw;
  assign DW             = r_dw;
  assign dbg_starve_cnt = r_starve_cnt;

  regfile_scoreboard u_scoreboard (
    .i_clk       (HCLK),
    .i_rst       (HRESET),
    .i_set_valid (rsv_valid),
    .i_set_rd    (rsv_rd),
    .i_clr_valid (r_wr),
    .i_clr_rd    (r_rw),
    .i_chk_ra    (chk_ra),
    .i_chk_rb    (chk_rb),
    .o_ra_busy   (ra_busy),
    .o_rb_busy   (rb_busy)
  );

endmodule
